// File: rtl/lc3_hazard_pkg.sv
// Shared types for the LC3 execute-stage hazard sequencer: opcodes, FSM states,
// the per-stage shadow record and the destination decoder.
package lc3_hazard_pkg;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LEA = 4'b1110;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_BUBBLE = 1'b1
    } haz_state_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] dr;
        logic       wr;
        logic       ld;
    } stage_info_t;

    localparam stage_info_t STAGE_EMPTY = '0;

    // Returns the destination record with valid=1; the caller qualifies valid.
    function automatic stage_info_t decode_info(input logic [15:0] ir);
        stage_info_t info;
        info.valid = 1'b1;
        info.dr    = ir[11:9];
        info.wr    = 1'b0;
        info.ld    = 1'b0;
        case (ir[15:12])
            OP_ADD, OP_AND, OP_NOT, OP_LEA: info.wr = 1'b1;
            OP_LD, OP_LDR, OP_LDI: begin
                info.wr = 1'b1;
                info.ld = 1'b1;
            end
            default: info.wr = 1'b0;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/lc3_hazard_ctrl_src_decode.sv
// Source-register decoder: extracts src1/src2 of an LC3 instruction and flags
// which of them the instruction actually reads.
module lc3_src_decode
    import lc3_hazard_pkg::*;
(
    input  logic [15:0] i_ir,
    output logic [2:0]  o_src1,
    output logic [2:0]  o_src2,
    output logic        o_use1,
    output logic        o_use2
);

    logic [3:0] w_op;
    logic       w_unused_ir_bits;

    assign w_op             = i_ir[15:12];
    assign w_unused_ir_bits = ^i_ir[4:3];
    assign o_src1           = i_ir[8:6];

    always_comb begin
        o_use1 = 1'b0;
        case (w_op)
            OP_ADD, OP_AND, OP_NOT, OP_LDR, OP_STR, OP_JMP: o_use1 = 1'b1;
            default: o_use1 = 1'b0;
        endcase
    end

    // Stores read their data register through the src2 path.
    always_comb begin
        o_src2 = i_ir[2:0];
        o_use2 = 1'b0;
        case (w_op)
            OP_ADD, OP_AND: begin
                o_src2 = i_ir[2:0];
                o_use2 = ~i_ir[5];
            end
            OP_ST, OP_STR, OP_STI: begin
                o_src2 = i_ir[11:9];
                o_use2 = 1'b1;
            end
            default: begin
                o_src2 = i_ir[2:0];
                o_use2 = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/lc3_hazard_ctrl.sv
// LC3 execute-stage hazard sequencer: bypass selects, stage enables and a
// one-cycle load-use bubble. Optional stall counter under LC3_HAZ_STATS_EN.
module lc3_hazard_ctrl
    import lc3_hazard_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        dec_valid,
    input  logic [15:0] dec_IR,
    input  logic        mem_busy,
    output logic        enable_fetch,
    output logic        enable_decode,
    output logic        enable_execute,
    output logic        ex_bubble,
    output logic        bypass_alu_1,
    output logic        bypass_alu_2,
    output logic        bypass_mem_1,
    output logic        bypass_mem_2
`ifdef LC3_HAZ_STATS_EN
    ,
    output logic [15:0] stall_count
`endif
);

    haz_state_t  r_state;
    haz_state_t  w_state_next;
    stage_info_t r_e;
    stage_info_t r_m;
    stage_info_t w_x_info;
    logic        r_ex_bubble;
    logic [1:0]  r_bypass_alu;
    logic [1:0]  r_bypass_mem;

    logic [2:0]  w_src [0:1];
    logic [1:0]  w_use;
    logic [1:0]  w_match_e;
    logic [1:0]  w_match_m;
    logic        w_hazard;
    logic        w_stall;
    logic        w_advance;

    lc3_src_decode u_src_decode (
        .i_ir   (dec_IR),
        .o_src1 (w_src[0]),
        .o_src2 (w_src[1]),
        .o_use1 (w_use[0]),
        .o_use2 (w_use[1])
    );

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_match
            assign w_match_e[gi] = r_e.valid & r_e.wr & w_use[gi] & (r_e.dr == w_src[gi]);
            assign w_match_m[gi] = r_m.valid & r_m.wr & w_use[gi] & (r_m.dr == w_src[gi]);
        end
    endgenerate

    always_comb begin
        w_x_info       = decode_info(dec_IR);
        w_x_info.valid = dec_valid;
    end

    // E is always invalid in BUBBLE, so the hazard cannot re-trigger there.
    assign w_hazard  = dec_valid & r_e.ld & (|w_match_e);
    assign w_stall   = (r_state == ST_RUN) & w_hazard;
    assign w_advance = ~mem_busy;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_advance) begin
            case (r_state)
                ST_RUN:    w_state_next = w_hazard ? ST_BUBBLE : ST_RUN;
                ST_BUBBLE: w_state_next = ST_RUN;
                default:   w_state_next = ST_RUN;
            endcase
        end
    end

    always_comb begin
        enable_execute = reset & ~mem_busy;
        enable_decode  = reset & ~mem_busy & ~w_stall;
        enable_fetch   = reset & ~mem_busy & ~w_stall;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_e          <= STAGE_EMPTY;
            r_m          <= STAGE_EMPTY;
            r_ex_bubble  <= 1'b1;
            r_bypass_alu <= 2'b00;
            r_bypass_mem <= 2'b00;
        end else if (w_advance) begin
            r_m <= r_e;
            if (w_stall) begin
                r_e          <= STAGE_EMPTY;
                r_ex_bubble  <= 1'b1;
                r_bypass_alu <= 2'b00;
                r_bypass_mem <= 2'b00;
            end else begin
                r_e          <= w_x_info;
                r_ex_bubble  <= ~dec_valid;
                // The younger producer in E wins over M for the same operand.
                r_bypass_alu <= w_match_e & {2{~r_e.ld}};
                r_bypass_mem <= ~w_match_e & w_match_m & {2{r_m.ld}};
            end
        end
    end

    assign ex_bubble    = r_ex_bubble;
    assign bypass_alu_1 = r_bypass_alu[0];
    assign bypass_alu_2 = r_bypass_alu[1];
    assign bypass_mem_1 = r_bypass_mem[0];
    assign bypass_mem_2 = r_bypass_mem[1];

`ifdef LC3_HAZ_STATS_EN
    logic [15:0] r_stall_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stall_count <= 16'h0000;
        end else if (w_advance && w_stall && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'h0001;
        end
    end

    assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_lc3_hazard_ctrl.sv
// Directed, table-driven bench for lc3_hazard_ctrl (stall counter checks are
// compiled in when LC3_HAZ_STATS_EN is defined).
module tb_lc3_hazard_ctrl;

    logic        clock;
    logic        reset;
    logic        dec_valid;
    logic [15:0] dec_IR;
    logic        mem_busy;
    logic        enable_fetch;
    logic        enable_decode;
    logic        enable_execute;
    logic        ex_bubble;
    logic        bypass_alu_1;
    logic        bypass_alu_2;
    logic        bypass_mem_1;
    logic        bypass_mem_2;
`ifdef LC3_HAZ_STATS_EN
    logic [15:0] stall_count;
`endif

    int n_tests;
    int n_fail;

    lc3_hazard_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .dec_valid      (dec_valid),
        .dec_IR         (dec_IR),
        .mem_busy       (mem_busy),
        .enable_fetch   (enable_fetch),
        .enable_decode  (enable_decode),
        .enable_execute (enable_execute),
        .ex_bubble      (ex_bubble),
        .bypass_alu_1   (bypass_alu_1),
        .bypass_alu_2   (bypass_alu_2),
        .bypass_mem_1   (bypass_mem_1),
        .bypass_mem_2   (bypass_mem_2)
`ifdef LC3_HAZ_STATS_EN
        ,
        .stall_count    (stall_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        valid;
        logic [15:0] ir;
        logic        busy;
        logic        en_dec;
        logic        en_ex;
        logic        bub;
        logic [1:0]  alu;   // {bypass_alu_2, bypass_alu_1}
        logic [1:0]  mem;   // {bypass_mem_2, bypass_mem_1}
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic valid, input logic [15:0] ir, input logic busy,
                                input logic en_dec, input logic en_ex, input logic bub,
                                input logic [1:0] alu, input logic [1:0] mem);
        vec_t v;
        v.valid = valid; v.ir = ir; v.busy = busy;
        v.en_dec = en_dec; v.en_ex = en_ex; v.bub = bub;
        v.alu = alu; v.mem = mem;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t t, input int idx);
        @(negedge clock);
        dec_valid = t.valid;
        dec_IR    = t.ir;
        mem_busy  = t.busy;
        #1;
        chk("enable_decode", idx, 16'(enable_decode), 16'(t.en_dec));
        chk("enable_fetch", idx, 16'(enable_fetch), 16'(t.en_dec));
        chk("enable_execute", idx, 16'(enable_execute), 16'(t.en_ex));
        @(posedge clock);
        #1;
        chk("ex_bubble", idx, 16'(ex_bubble), 16'(t.bub));
        chk("bypass_alu", idx, 16'({bypass_alu_2, bypass_alu_1}), 16'(t.alu));
        chk("bypass_mem", idx, 16'({bypass_mem_2, bypass_mem_1}), 16'(t.mem));
        $display("[TB] step %0d ir=%h v=%b busy=%b en_dec=%b en_ex=%b bub=%b alu=%b mem=%b",
                 idx, t.ir, t.valid, t.busy, enable_decode, enable_execute, ex_bubble,
                 {bypass_alu_2, bypass_alu_1}, {bypass_mem_2, bypass_mem_1});
    endtask

    task automatic drive(input logic valid, input logic [15:0] ir);
        @(negedge clock);
        dec_valid = valid;
        dec_IR    = ir;
        mem_busy  = 1'b0;
        @(posedge clock);
        #1;
        $display("[TB] seq ir=%h bub=%b alu=%b mem=%b", ir, ex_bubble,
                 {bypass_alu_2, bypass_alu_1}, {bypass_mem_2, bypass_mem_1});
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b0;
        dec_valid = 1'b1;
        dec_IR    = 16'h1845;
        mem_busy  = 1'b0;

        //              valid ir       busy en_d en_e bub  alu    mem
        vecs.push_back(mk(1, 16'h1283, 0, 1, 1, 0, 2'b00, 2'b00)); // E=R1
        vecs.push_back(mk(1, 16'h1845, 0, 1, 1, 0, 2'b01, 2'b00)); // ALU src1
        vecs.push_back(mk(1, 16'h1283, 1, 0, 0, 0, 2'b01, 2'b00)); // freeze holds outputs
        vecs.push_back(mk(1, 16'h1283, 0, 1, 1, 0, 2'b00, 2'b00));
        vecs.push_back(mk(1, 16'h1941, 0, 1, 1, 0, 2'b10, 2'b00)); // ALU src2
        vecs.push_back(mk(1, 16'h1283, 0, 1, 1, 0, 2'b00, 2'b00));
        vecs.push_back(mk(1, 16'h1961, 0, 1, 1, 0, 2'b00, 2'b00)); // immediate: no src2
        vecs.push_back(mk(0, 16'h1845, 0, 1, 1, 1, 2'b00, 2'b00)); // invalid X, M non-load
        vecs.push_back(mk(1, 16'h6280, 0, 1, 1, 0, 2'b00, 2'b00)); // LDR R1
        vecs.push_back(mk(1, 16'h1845, 0, 0, 1, 1, 2'b00, 2'b00)); // load-use stall
        vecs.push_back(mk(1, 16'h1845, 0, 1, 1, 0, 2'b00, 2'b01)); // mem bypass src1
        vecs.push_back(mk(1, 16'h6280, 0, 1, 1, 0, 2'b00, 2'b00));
        vecs.push_back(mk(1, 16'h1283, 0, 1, 1, 0, 2'b00, 2'b00)); // E=R1 ALU, M=R1 load
        vecs.push_back(mk(1, 16'h1845, 0, 1, 1, 0, 2'b01, 2'b00)); // ALU beats mem
        vecs.push_back(mk(1, 16'h6280, 0, 1, 1, 0, 2'b00, 2'b00));
        vecs.push_back(mk(1, 16'h1A83, 0, 1, 1, 0, 2'b00, 2'b00)); // E=R5, M=R1 load
        vecs.push_back(mk(1, 16'h1845, 0, 1, 1, 0, 2'b10, 2'b01)); // both paths, diff operands
        vecs.push_back(mk(1, 16'h3800, 0, 1, 1, 0, 2'b10, 2'b00)); // ST reads R4 via src2
        vecs.push_back(mk(1, 16'h3800, 0, 1, 1, 0, 2'b00, 2'b00)); // ST never writes
        vecs.push_back(mk(1, 16'h6280, 0, 1, 1, 0, 2'b00, 2'b00));
        vecs.push_back(mk(1, 16'h1845, 1, 0, 0, 0, 2'b00, 2'b00)); // hazard under freeze
        vecs.push_back(mk(1, 16'h1845, 1, 0, 0, 0, 2'b00, 2'b00));
        vecs.push_back(mk(1, 16'h1845, 1, 0, 0, 0, 2'b00, 2'b00));
        vecs.push_back(mk(1, 16'h1845, 0, 0, 1, 1, 2'b00, 2'b00)); // acted on after freeze
        vecs.push_back(mk(1, 16'h1845, 1, 0, 0, 1, 2'b00, 2'b00)); // freeze in BUBBLE
        vecs.push_back(mk(1, 16'h1845, 0, 1, 1, 0, 2'b00, 2'b01));

        // Reset state with a valid instruction presented.
        @(posedge clock);
        @(posedge clock);
        #1;
        chk("rst_enable_decode", -1, 16'(enable_decode), 16'h0);
        chk("rst_enable_fetch", -1, 16'(enable_fetch), 16'h0);
        chk("rst_enable_execute", -1, 16'(enable_execute), 16'h0);
        chk("rst_ex_bubble", -1, 16'(ex_bubble), 16'h1);
        chk("rst_bypass", -1, 16'({bypass_alu_2, bypass_alu_1, bypass_mem_2, bypass_mem_1}), 16'h0);
`ifdef LC3_HAZ_STATS_EN
        chk("rst_stall_count", -1, stall_count, 16'h0);
`endif
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

`ifdef LC3_HAZ_STATS_EN
        chk("stall_count_table", 100, stall_count, 16'd2);
`endif

        // Reset asserted while the bubble is in execute.
        drive(1'b1, 16'h6280);
        drive(1'b1, 16'h1845);
        chk("pre_reset_bubble", 200, 16'(ex_bubble), 16'h1);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("midrst_enable_decode", 201, 16'(enable_decode), 16'h0);
        chk("midrst_enable_execute", 201, 16'(enable_execute), 16'h0);
        chk("midrst_ex_bubble", 201, 16'(ex_bubble), 16'h1);
        chk("midrst_bypass", 201, 16'({bypass_alu_2, bypass_alu_1, bypass_mem_2, bypass_mem_1}), 16'h0);
`ifdef LC3_HAZ_STATS_EN
        chk("midrst_stall_count", 201, stall_count, 16'h0);
`endif
        @(posedge clock);
        #1;
        chk("midrst_hold_enable_fetch", 202, 16'(enable_fetch), 16'h0);
        @(negedge clock);
        reset     = 1'b1;
        dec_valid = 1'b1;
        dec_IR    = 16'h1845;
        #1;
        chk("postrst_enable_decode", 203, 16'(enable_decode), 16'h1);
        @(posedge clock);
        #1;
        chk("postrst_ex_bubble", 203, 16'(ex_bubble), 16'h0);
        chk("postrst_bypass", 203, 16'({bypass_alu_2, bypass_alu_1, bypass_mem_2, bypass_mem_1}), 16'h0);
        $display("[TB] post-reset ir=1845 bub=%b alu=%b mem=%b", ex_bubble,
                 {bypass_alu_2, bypass_alu_1}, {bypass_mem_2, bypass_mem_1});

`ifdef LC3_HAZ_STATS_EN
        // Counter saturation from a preloaded value.
        @(negedge clock);
        force dut.r_stall_count = 16'hFFFE;
        @(negedge clock);
        release dut.r_stall_count;
        drive(1'b1, 16'h6280);
        drive(1'b1, 16'h1845);
        drive(1'b1, 16'h1845);
        chk("sat_first", 300, stall_count, 16'hFFFF);
        drive(1'b1, 16'h6280);
        drive(1'b1, 16'h1845);
        drive(1'b1, 16'h1845);
        chk("sat_hold", 301, stall_count, 16'hFFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
